// File: rtl/uart_sequencer.sv
// Bus master for a single UART: programs CLK_DIV, polls STATUS, drains a TX FIFO
// into DATA and hands received bytes to a valid/ready consumer (RX has priority).
module uart_sequencer #(
    parameter logic [15:0] CLK_DIV_RESET = 16'd103,
    parameter int unsigned TX_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tx_valid_in,
    output logic        tx_ready_out,
    input  logic [7:0]  tx_data_in,
    output logic        rx_valid_out,
    input  logic        rx_ready_in,
    output logic [7:0]  rx_data_out,
    input  logic [15:0] clk_div_in,
    input  logic        clk_div_load_in,
    output logic        busy_out,
    output logic [31:0] address_out,
    output logic        sel_out,
    output logic        read_out,
    input  logic [31:0] read_value_in,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out
);

    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(TX_DEPTH);

    typedef enum logic [1:0] {
        S_INIT,
        S_POLL,
        S_RX_RD,
        S_TX_WR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_fifo [TX_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_rx_valid;
    logic [7:0]      r_rx_data;
    logic [15:0]     r_clk_div;
    logic            r_load_pending;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_st;
    logic            w_unused_rd;

    assign w_st         = read_value_in[1:0];
    assign w_unused_rd  = ^read_value_in[31:8];
    assign tx_ready_out = (r_count != FULL);
    assign w_push       = tx_valid_in & tx_ready_out;
    assign w_pop        = (r_state == S_TX_WR);
    assign rx_valid_out = r_rx_valid;
    assign rx_data_out  = r_rx_data;
    assign busy_out     = (r_count != '0) | (r_state != S_POLL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // POLL decisions use the registered FIFO count and rx_valid, so a same-cycle
    // push or consumer handshake only becomes visible on the following POLL.
    always_comb begin
        w_next          = r_state;
        address_out     = '0;
        sel_out         = 1'b1;
        read_out        = 1'b0;
        write_mask_out  = '0;
        write_value_out = '0;
        case (r_state)
            S_INIT: begin
                address_out     = 32'h0;
                write_mask_out  = 4'b0011;
                write_value_out = {16'b0, r_clk_div};
                w_next          = S_POLL;
            end
            S_POLL: begin
                address_out = 32'h4;
                read_out    = 1'b1;
                if (r_load_pending) begin
                    w_next = S_INIT;
                end else if (w_st[1] && !r_rx_valid) begin
                    w_next = S_RX_RD;
                end else if (w_st[0] && (r_count != '0)) begin
                    w_next = S_TX_WR;
                end else begin
                    w_next = S_POLL;
                end
            end
            S_RX_RD: begin
                address_out = 32'h8;
                read_out    = 1'b1;
                w_next      = S_POLL;
            end
            S_TX_WR: begin
                address_out     = 32'h8;
                write_mask_out  = 4'b0001;
                write_value_out = {24'b0, r_fifo[r_rd_ptr]};
                w_next          = S_POLL;
            end
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= tx_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else if (r_state == S_RX_RD) begin
            r_rx_data  <= read_value_in[7:0];
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && rx_ready_in) begin
            r_rx_valid <= 1'b0;
        end
    end

    // A load arriving while INIT is on the bus wins over INIT's clear,
    // forcing a second INIT with the new divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_div      <= CLK_DIV_RESET;
            r_load_pending <= 1'b0;
        end else if (clk_div_load_in) begin
            r_clk_div      <= clk_div_in;
            r_load_pending <= 1'b1;
        end else if (r_state == S_INIT) begin
            r_load_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_sequencer.sv
// Directed bench for uart_sequencer: a transaction-level model of the bus sequence
// is compared every cycle, plus literal checks for the documented scenarios.
module tb_uart_sequencer;

    localparam int PH_CFG  = 0;
    localparam int PH_STAT = 1;
    localparam int PH_RX   = 2;
    localparam int PH_TX   = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tx_valid_in;
    logic        tx_ready_out;
    logic [7:0]  tx_data_in;
    logic        rx_valid_out;
    logic        rx_ready_in;
    logic [7:0]  rx_data_out;
    logic [15:0] clk_div_in;
    logic        clk_div_load_in;
    logic        busy_out;
    logic [31:0] address_out;
    logic        sel_out;
    logic        read_out;
    logic [31:0] read_value_in;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;

    logic [1:0]  status;
    logic [7:0]  rx_byte;

    int checks = 0;
    int errors = 0;

    // model state
    int          m_ph;
    logic [7:0]  q [$];
    bit          m_rxv;
    logic [7:0]  m_rxd;
    logic [15:0] m_div;
    bit          m_pend;
    int          m_nph;
    bit          m_push;
    bit          m_hs;
    logic [7:0]  wr_log [$];

    always #5 clk = ~clk;

    assign read_value_in = (address_out == 32'h4) ? {30'b0, status} :
                           (address_out == 32'h8) ? {24'b0, rx_byte} : 32'hDEADBEEF;

    uart_sequencer #(.CLK_DIV_RESET(16'd103), .TX_DEPTH(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tx_valid_in     (tx_valid_in),
        .tx_ready_out    (tx_ready_out),
        .tx_data_in      (tx_data_in),
        .rx_valid_out    (rx_valid_out),
        .rx_ready_in     (rx_ready_in),
        .rx_data_out     (rx_data_out),
        .clk_div_in      (clk_div_in),
        .clk_div_load_in (clk_div_load_in),
        .busy_out        (busy_out),
        .address_out     (address_out),
        .sel_out         (sel_out),
        .read_out        (read_out),
        .read_value_in   (read_value_in),
        .write_mask_out  (write_mask_out),
        .write_value_out (write_value_out)
    );

    // Transaction-level model: which bus cycle comes next, the FIFO as a queue.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph   = PH_CFG;
            q.delete();
            m_rxv  = 1'b0;
            m_rxd  = 8'h00;
            m_div  = 16'd103;
            m_pend = 1'b0;
        end else begin
            m_push = tx_valid_in && (q.size() != 4);
            m_hs   = m_rxv && rx_ready_in;
            m_nph  = PH_STAT;
            case (m_ph)
                PH_CFG:  m_pend = 1'b0;
                PH_STAT: begin
                    if (m_pend) m_nph = PH_CFG;
                    else if (status[1] && !m_rxv) m_nph = PH_RX;
                    else if (status[0] && q.size() > 0) m_nph = PH_TX;
                end
                PH_RX:   m_rxd = rx_byte;
                PH_TX:   if (q.size() > 0) void'(q.pop_front());
                default: m_nph = PH_CFG;
            endcase
            if (m_hs) m_rxv = 1'b0;
            if (m_ph == PH_RX) m_rxv = 1'b1;
            if (m_push) q.push_back(tx_data_in);
            if (clk_div_load_in) begin
                m_div  = clk_div_in;
                m_pend = 1'b1;
            end
            m_ph = m_nph;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [31:0] e_addr, e_wv, a_wv;
        logic [3:0]  e_mask;
        logic        e_rd, e_busy, e_txr;
        e_addr = (m_ph == PH_CFG) ? 32'h0 : (m_ph == PH_STAT) ? 32'h4 : 32'h8;
        e_rd   = (m_ph == PH_STAT) || (m_ph == PH_RX);
        e_mask = (m_ph == PH_CFG) ? 4'b0011 : (m_ph == PH_TX) ? 4'b0001 : 4'b0000;
        e_wv   = (m_ph == PH_CFG) ? {16'b0, m_div} :
                 (m_ph == PH_TX && q.size() > 0) ? {24'b0, q[0]} : 32'h0;
        a_wv   = (e_mask != 4'b0000) ? write_value_out : 32'h0;
        e_txr  = (q.size() != 4);
        e_busy = (q.size() != 0) || (m_ph != PH_STAT);
        checks++;
        if (sel_out !== 1'b1 || address_out !== e_addr || read_out !== e_rd ||
            write_mask_out !== e_mask || a_wv !== e_wv || tx_ready_out !== e_txr ||
            busy_out !== e_busy || rx_valid_out !== m_rxv || rx_data_out !== m_rxd) begin
            errors++;
            $display("FAIL model_cmp t=%0t got sel=%b addr=%h rd=%b mask=%b wv=%h txr=%b busy=%b rxv=%b rxd=%h expected sel=1 addr=%h rd=%b mask=%b wv=%h txr=%b busy=%b rxv=%b rxd=%h",
                     $time, sel_out, address_out, read_out, write_mask_out, a_wv, tx_ready_out,
                     busy_out, rx_valid_out, rx_data_out, e_addr, e_rd, e_mask, e_wv, e_txr,
                     e_busy, m_rxv, m_rxd);
        end
        if (reset_n && write_mask_out == 4'b0001) wr_log.push_back(write_value_out[7:0]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; tx_valid_in = 1'b0; tx_data_in = 8'h00; rx_ready_in = 1'b0;
        clk_div_in = 16'h0; clk_div_load_in = 1'b0; status = 2'b00; rx_byte = 8'h00;
        repeat (2) step();
        chk("rst_addr", address_out, 32'h0);
        chk("rst_mask", {28'b0, write_mask_out}, 32'h3);
        chk("rst_wv", write_value_out, 32'h00000067);
        chk("rst_txready", {31'b0, tx_ready_out}, 32'h1);
        chk("rst_rxvalid", {31'b0, rx_valid_out}, 32'h0);
        reset_n = 1'b1;
        step();
        chk("poll_addr", address_out, 32'h4);
        chk("poll_read", {31'b0, read_out}, 32'h1);

        // single TX byte
        tx_valid_in = 1'b1; tx_data_in = 8'h55; status = 2'b01;
        step();
        tx_valid_in = 1'b0;
        step();
        chk("tx_mask", {28'b0, write_mask_out}, 32'h1);
        chk("tx_wv", write_value_out, 32'h00000055);
        step();
        chk("tx_empty_busy", {31'b0, busy_out}, 32'h0);
        status = 2'b00;

        // RX takes priority over pending TX
        tx_valid_in = 1'b1; tx_data_in = 8'h66;
        step();
        tx_valid_in = 1'b0; status = 2'b11; rx_byte = 8'hA5;
        step();
        chk("rxrd_addr", address_out, 32'h8);
        chk("rxrd_read", {31'b0, read_out}, 32'h1);
        step();
        chk("rx_data", {24'b0, rx_data_out}, 32'hA5);
        chk("rx_valid", {31'b0, rx_valid_out}, 32'h1);
        step();
        chk("tx_after_rx", write_value_out, 32'h00000066);
        step();

        // consumer stall: no DATA read while a byte is held
        status = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", address_out, 32'h4);
        end
        rx_ready_in = 1'b1;
        step();
        rx_ready_in = 1'b0; rx_byte = 8'h3C;
        chk("hs_still_poll", address_out, 32'h4);
        step();
        chk("rx2_addr", address_out, 32'h8);
        step();
        chk("rx2_data", {24'b0, rx_data_out}, 32'h3C);
        rx_ready_in = 1'b1; status = 2'b00;
        step();
        rx_ready_in = 1'b0;

        // fill FIFO, then drain in order
        tx_valid_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tx_data_in = 8'(i);
            step();
        end
        chk("full_ready", {31'b0, tx_ready_out}, 32'h0);
        tx_data_in = 8'h05;
        step();
        tx_valid_in = 1'b0;
        wr_log.delete();
        status = 2'b01;
        for (int i = 0; i < 40 && wr_log.size() < 4; i++) step();
        repeat (4) step();
        chk("drain_count", wr_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            chk("drain_order", {24'b0, wr_log[i]}, 32'(i + 1));
        chk("drain_empty", {31'b0, busy_out}, 32'h0);

        // divider reload during TX traffic
        status = 2'b00; tx_valid_in = 1'b1; tx_data_in = 8'hAA;
        step();
        tx_data_in = 8'hBB;
        step();
        tx_valid_in = 1'b0; status = 2'b01;
        step();
        chk("ld_tx_wv", write_value_out, 32'h000000AA);
        clk_div_load_in = 1'b1; clk_div_in = 16'h0010;
        step();
        clk_div_load_in = 1'b0;
        chk("ld_poll", address_out, 32'h4);
        step();
        chk("ld_init_addr", address_out, 32'h0);
        chk("ld_init_wv", write_value_out, 32'h00000010);
        step();
        step();
        chk("ld_tx2_wv", write_value_out, 32'h000000BB);
        step();

        // reset during TX_WR
        status = 2'b00; tx_valid_in = 1'b1; tx_data_in = 8'hCC;
        step();
        tx_data_in = 8'hDD;
        step();
        tx_valid_in = 1'b0; status = 2'b01;
        step();
        chk("rst_tx_wv", write_value_out, 32'h000000CC);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", address_out, 32'h0);
        chk("mid_rst_wv", write_value_out, 32'h00000067);
        chk("mid_rst_txready", {31'b0, tx_ready_out}, 32'h1);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_poll", address_out, 32'h4);
        step();
        chk("post_rst_mask", {28'b0, write_mask_out}, 32'h0);
        chk("post_rst_busy", {31'b0, busy_out}, 32'h0);

        // load while INIT is on the bus yields a second INIT
        #2 reset_n = 1'b0;
        step();
        reset_n = 1'b1; clk_div_load_in = 1'b1; clk_div_in = 16'h0020;
        step();
        clk_div_load_in = 1'b0;
        chk("init_ld_poll", address_out, 32'h4);
        step();
        chk("init_ld_again", address_out, 32'h0);
        chk("init_ld_wv", write_value_out, 32'h00000020);
        step();
        chk("init_ld_back", address_out, 32'h4);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
